sort4_frame_streamer: RTL
=========================

// Module: sort4_frame_streamer
// PURPOSE
//  Stream front/back end for the 4-entry bubble sorter (Sorter4).
//  - Collects up to 4 W-bit words from a valid/ready input stream.
//  - Drives the sorter's parallel inputs and load pin, waits for its done flag.
//  - Captures the sorted words and replays them ascending on a valid/ready output
//    stream, with a last marker on the final word.
//  Sorter4 sits beside this block: sort_x*/sort_load feed it; sort_s*/sort_done return.
// PARAMETERS
//  W    4    data word width; must match the sorter's W
// PORTS
//  clock       in   1    system clock, all state on posedge
//  reset       in   1    synchronous, active-high
//  in_data     in   W    input word
//  in_valid    in   1    in_data valid
//  in_last     in   1    marks final word of a short frame (ignored on 4th word)
//  in_ready    out  1    block accepts a word this cycle
//  sort_x0..3  out  W    frame words to sorter (held stable from LOAD to next FILL)
//  sort_load   out  1    one-cycle pulse; connects to the sorter's reset/load pin
//  sort_s0..3  in   W    sorter results, ascending
//  sort_done   in   1    sorter finished
//  out_data    out  W    sorted output word
//  out_valid   out  1    out_data valid
//  out_last    out  1    high with the final valid word of the frame
//  out_ready   in   1    downstream accepts out_data
//  busy        out  1    high in any state other than FILL
// BEHAVIOUR
//  Clocking and reset
//  - reset: reset, synchronous, active-high; clock: clock.
//  - reset wins over everything, including mid-frame. It forces:
//    FILL, cnt=0, in_ready=1, sort_load=0, out_valid=0, out_last=0, busy=0,
//    sort_x*/out_data = 0.
//  FSM: FILL -> LOAD -> WAIT -> DRAIN -> FILL
//  - FILL: in_ready=1. Each in_valid&in_ready writes in_data to slot cnt and increments
//    cnt (3 bits, 0..4).
//    - Go to LOAD when the 4th word is accepted, or when a word is accepted with
//      in_last=1 (frame length n = cnt+1).
//    - On that same edge, slots >= n are filled with {W{1'b1}}, so padding sorts last.
//    - in_last with no valid word has no effect; cnt is never 0 on leaving FILL.
//  - LOAD: exactly 1 cycle. sort_load=1, in_ready=0.
//  - WAIT: ignore sort_done in the LOAD cycle (it may be stale high from the previous
//    frame). sort_done is sampled from the first WAIT cycle onward.
//    - When sort_done=1: capture sort_s0..3 into the output buffer on that edge, go to
//      DRAIN, idx=0.
//    - Nominal: sort_done rises 4 cycles after the LOAD edge. No timeout; WAIT holds
//      indefinitely.
//  - DRAIN: out_valid=1, out_data=buf[idx], out_last=(idx==n-1).
//    - out_data is stable while out_valid&!out_ready.
//    - On out_ready: idx++. After the beat with out_last, go to FILL, cnt=0, n cleared.
//    - in_ready=0 throughout; no overlap between frames.
//  Latency and throughput
//  - Latency (full frame, out_ready tied 1): accept of 4th word at edge E0;
//    LOAD during cycle E0..E1; sort_done seen in cycle after E4; first out_valid
//    after E5.
//  - Throughput: one frame per 4+1+4+4 = 13 cycles minimum.
//  - Padding words are never emitted; output count always equals n (1..4).
// TESTING
//  1. Full frame 9,3,7,1 (W=4), out_ready=1 -> out 1,3,7,9; out_last only on 9;
//     sort_load a single 1-cycle pulse.
//  2. Short frame 5,2 with in_last on 2 -> sort_x = 5,2,F,F; out 2,5, out_last on 5;
//     exactly 2 beats.
//  3. Out_ready toggled 1,0,0,1... during DRAIN of 4,4,0,F -> out 0,4,4,F;
//     data held during stalls; no drop or duplicate.
//  4. in_valid asserted during LOAD/WAIT/DRAIN -> in_ready=0, no word consumed;
//     next frame starts cleanly with cnt=0.
//  5. sort_done already high entering LOAD (previous frame) -> no early capture;
//     capture waits for the fresh done.
//  6. reset pulsed in WAIT and in DRAIN mid-frame -> next cycle FILL, out_valid=0,
//     cnt=0; next frame 8,6,2,A sorts to 2,6,8,A.

Source files
------------

// File: rtl/sort4_frame_streamer.sv
// sort4_frame_streamer
// Stream front/back end for a 4-entry sorter. Collects a frame of 1..4 words,
// pads the unused slots with all-ones so they sort last, and pulses the
// sorter's load pin. It then waits for the sorter's done flag, captures the
// ascending results and replays the first n of them on a valid/ready output
// stream, with a last marker on the final word. Only one frame is in flight.

module sort4_frame_streamer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  // input stream
  input  logic [W-1:0] i_in_data,
  input  logic         i_in_valid,
  input  logic         i_in_last,
  output logic         o_in_ready,
  // sorter interface
  output logic [W-1:0] o_sort_x0,
  output logic [W-1:0] o_sort_x1,
  output logic [W-1:0] o_sort_x2,
  output logic [W-1:0] o_sort_x3,
  output logic         o_sort_load,
  input  logic [W-1:0] i_sort_s0,
  input  logic [W-1:0] i_sort_s1,
  input  logic [W-1:0] i_sort_s2,
  input  logic [W-1:0] i_sort_s3,
  input  logic         i_sort_done,
  // output stream
  output logic [W-1:0] o_out_data,
  output logic         o_out_valid,
  output logic         o_out_last,
  input  logic         i_out_ready,
  // status
  output logic         o_busy
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t       r_state;
  logic [2:0]   r_cnt;          // words accepted so far in FILL (0..4)
  logic [2:0]   r_n;            // frame length, valid from LOAD to end of DRAIN
  logic [1:0]   r_idx;          // index of the word currently on o_out_data
  logic [W-1:0] r_slot [4];     // frame words, drive the sorter inputs directly
  logic [W-1:0] r_buf  [4];     // sorted words captured on sort_done
  logic         r_in_ready;
  logic         r_sort_load;
  logic         r_out_valid;
  logic         r_out_last;
  logic         r_busy;
  logic [W-1:0] r_out_data;

  logic         w_in_fire;
  logic         w_frame_end;
  logic         w_out_fire;

  assign w_in_fire   = i_in_valid && r_in_ready;
  // The 4th word closes the frame regardless of in_last.
  assign w_frame_end = (r_cnt == 3'd3) || i_in_last;
  assign w_out_fire  = r_out_valid && i_out_ready;

  assign o_in_ready  = r_in_ready;
  assign o_sort_load = r_sort_load;
  assign o_sort_x0   = r_slot[0];
  assign o_sort_x1   = r_slot[1];
  assign o_sort_x2   = r_slot[2];
  assign o_sort_x3   = r_slot[3];
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_busy      = r_busy;

  // Control FSM with registered outputs; every output is set on the edge that
  // enters the state it belongs to.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_FILL;
      r_cnt       <= 3'd0;
      r_n         <= 3'd0;
      r_idx       <= 2'd0;
      r_in_ready  <= 1'b1;
      r_sort_load <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= '0;
      for (int k = 0; k < 4; k++) r_slot[k] <= '0;
    end else begin
      // Load is a single-cycle pulse: it is only ever raised on the FILL exit.
      r_sort_load <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_in_fire) begin
            for (int k = 0; k < 4; k++) begin
              if (k == int'(r_cnt)) begin
                r_slot[k] <= i_in_data;
              end else if (w_frame_end && (k > int'(r_cnt))) begin
                r_slot[k] <= '1;
              end
            end
            r_cnt <= r_cnt + 3'd1;
            if (w_frame_end) begin
              r_n         <= r_cnt + 3'd1;
              r_state     <= S_LOAD;
              r_in_ready  <= 1'b0;
              r_sort_load <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          // sort_done may still be high from the previous frame; it is not
          // looked at until WAIT.
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_sort_done) begin
            r_out_data  <= i_sort_s0;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_n == 3'd1);
            r_idx       <= 2'd0;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_out_fire) begin
            if (r_out_last) begin
              r_state     <= S_FILL;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_cnt       <= 3'd0;
              r_n         <= 3'd0;
            end else begin
              r_idx      <= r_idx + 2'd1;
              r_out_data <= r_buf[r_idx + 2'd1];
              r_out_last <= ((3'(r_idx) + 3'd2) == r_n);
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  // Capture buffer for the sorter results, written once per frame.
  // NOTE: the buffer has no reset; it is always written before it is read,
  // so clearing it would only add logic.
  always_ff @(posedge clock) begin
    if (r_state == S_WAIT && i_sort_done) begin
      r_buf[0] <= i_sort_s0;
      r_buf[1] <= i_sort_s1;
      r_buf[2] <= i_sort_s2;
      r_buf[3] <= i_sort_s3;
    end
  end

endmodule
